// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: phase encoding, lamp codes, phase sequencing.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package traffic_pkg;

    // Width of the seconds-remaining counter; covers durations up to 99.
    localparam int CNT_W = 7;

    // Phase encoding is visible on the phase output, so the values are fixed.
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } phase_t;

    // Lamp codes, {R,Y,G}, one-hot.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Reset lands in the clearance phase that precedes north-south green.
    localparam phase_t RESET_PHASE = ALLRED_B;

    // Fixed cycle order; the unused encodings fall back to the reset phase.
    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALLRED_A;
            ALLRED_A:  n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALLRED_B;
            ALLRED_B:  n = NS_GREEN;
            default:   n = RESET_PHASE;
        endcase
        return n;
    endfunction

    // Green phases are the only ones a pedestrian request can shorten.
    function automatic logic is_green(input phase_t p);
        return (p == NS_GREEN) || (p == EW_GREEN);
    endfunction

endpackage

// File: rtl/tl_bin2bcd.sv
// Binary (0..99) to two-digit BCD {tens,units}, shared with the display stage.
// Latency: purely combinational.
// Backpressure: none.
module tl_bin2bcd
    import traffic_pkg::*;
(
    input  logic [CNT_W-1:0] bin,
    output logic [7:0]       bcd
);

    logic [3:0] tens;
    logic [3:0] units;

    // Tens digit is the largest multiple of ten not above the input; units is the remainder.
    always_comb begin
        tens = 4'd0;
        for (int t = 1; t <= 9; t++) begin
            if (bin >= CNT_W'(t * 10)) begin
                tens = 4'(t);
            end
        end
        units = 4'(bin - CNT_W'(tens) * CNT_W'(10));
    end

    assign bcd = {tens, units};

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way traffic-light sequencer, one step per 1 Hz clk, with BCD countdown of the phase.
// Latency: lamps, phase and countdown change on the same edge as the state; no input-to-output path.
// Backpressure: none; optional pedestrian shortening of green under TRAFFIC_PED_EN.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int T_GREEN   = 25,
    parameter int T_YELLOW  = 3,
    parameter int T_ALLRED  = 2,
    parameter int T_PED_MIN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [7:0] cnt_bcd,
    output logic [2:0] phase,
    output logic       ped_wait
);

    phase_t           state_q;
    phase_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             phase_end;
    logic             ped_cut;

    // Duration loaded on entry to each phase.
    function automatic logic [CNT_W-1:0] phase_len(input phase_t p);
        logic [CNT_W-1:0] len;
        case (p)
            NS_GREEN, EW_GREEN:   len = CNT_W'(T_GREEN);
            NS_YELLOW, EW_YELLOW: len = CNT_W'(T_YELLOW);
            default:              len = CNT_W'(T_ALLRED);
        endcase
        return len;
    endfunction

    // The counter includes the current second, so 1 marks the last second of a phase.
    assign phase_end = (cnt_q == CNT_W'(1));

`ifdef TRAFFIC_PED_EN
    logic ped_pending_q;
    logic ped_pending_d;

    // Cut only when it actually shortens the green; a phase change always wins.
    assign ped_cut = is_green(state_q) && ped_pending_q && (cnt_q > CNT_W'(T_PED_MIN));

    // Any green edge services the request (cut or not); a fresh press on the same edge re-arms it.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (is_green(state_q)) begin
            ped_pending_d = 1'b0;
        end
        if (ped_req) begin
            ped_pending_d = 1'b1;
        end
    end

    // Pending-request register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_pending_q <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
        end
    end

    assign ped_wait = ped_pending_q;
`else
    // Port kept for a uniform pinout; the request has no effect in this build.
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_cut        = 1'b0;
    assign ped_wait       = 1'b0;
`endif

    // State register: phase and seconds remaining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_PHASE;
            cnt_q   <= CNT_W'(T_ALLRED);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance and reload on the last second, else cut or count down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CNT_W'(1);
        if (phase_end) begin
            state_d = next_phase(state_q);
            cnt_d   = phase_len(next_phase(state_q));
        end else if (ped_cut) begin
            cnt_d   = CNT_W'(T_PED_MIN);
        end
    end

    // Outputs: lamp pair decoded from the registered phase; anything unexpected shows red.
    always_comb begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
        case (state_q)
            NS_GREEN:  ns_light = LAMP_G;
            NS_YELLOW: ns_light = LAMP_Y;
            EW_GREEN:  ew_light = LAMP_G;
            EW_YELLOW: ew_light = LAMP_Y;
            default: begin
                ns_light = LAMP_R;
                ew_light = LAMP_R;
            end
        endcase
    end

    assign phase = state_q;

    tl_bin2bcd u_bin2bcd (
        .bin (cnt_q),
        .bcd (cnt_bcd)
    );

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: stimulus pushes the expected post-edge state per cycle.
// Latency: expectations describe the state visible after the edge following each stimulus step.
// Backpressure: n/a; the monitor pops one expectation per falling edge.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

`ifdef TRAFFIC_PED_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [7:0] cnt_bcd;
    logic [2:0] phase;
    logic       ped_wait;

    typedef struct {
        phase_t ph;
        int     c;
        bit     pw;
        int     idx;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   seq         = 0;

    traffic_light_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .cnt_bcd  (cnt_bcd),
        .phase    (phase),
        .ped_wait (ped_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lamp pair {ns,ew} for each phase, straight from the lamp table.
    function automatic logic [5:0] lamps(input phase_t p);
        logic [5:0] l;
        case (p)
            NS_GREEN:  l = {3'b001, 3'b100};
            NS_YELLOW: l = {3'b010, 3'b100};
            EW_GREEN:  l = {3'b100, 3'b001};
            EW_YELLOW: l = {3'b100, 3'b010};
            default:   l = {3'b100, 3'b100};
        endcase
        return l;
    endfunction

    function automatic logic [7:0] to_bcd(input int c);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(c / 10);
        u = 4'(c % 10);
        return {t, u};
    endfunction

    // One cycle of stimulus: drive inputs after the falling edge, queue the state expected after the next rising edge.
    task automatic step(input bit rs, input bit rq, input phase_t ph, input int c, input bit pw);
        exp_t e;
        @(negedge clk);
        #1;
        rst     = rs;
        ped_req = rq;
        if (rs) begin
            // Asynchronous reset must already show on the outputs, before any clock edge.
            #1;
            vectors++;
            if (phase !== 3'(ALLRED_B) || cnt_bcd !== 8'h02 || ns_light !== 3'b100
                || ew_light !== 3'b100 || ped_wait !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset @%0t: got phase=%0d bcd=%h ns=%b ew=%b pw=%b, need phase=5 bcd=02 ns=100 ew=100 pw=0",
                         $time, phase, cnt_bcd, ns_light, ew_light, ped_wait);
            end
        end
        e.ph  = ph;
        e.c   = c;
        e.pw  = pw;
        e.idx = seq;
        seq++;
        q.push_back(e);
    endtask

    // Run a phase down from cnt 'from' to 'to' with no pedestrian press.
    task automatic seg(input phase_t ph, input int from, input int to, input bit pw);
        for (int c = from; c >= to; c--) begin
            step(1'b0, 1'b0, ph, c, pw);
        end
    endtask

    // Monitor: compare each visible cycle against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [5:0] l;
            logic [7:0] b;
            e = q.pop_front();
            l = lamps(e.ph);
            b = to_bcd(e.c);
            vectors++;
            if (phase !== 3'(e.ph) || cnt_bcd !== b || ns_light !== l[5:3]
                || ew_light !== l[2:0] || ped_wait !== e.pw) begin
                miscompares++;
                $display("FAIL cycle%0d @%0t: got phase=%0d bcd=%h ns=%b ew=%b pw=%b, need phase=%0d bcd=%h ns=%b ew=%b pw=%b",
                         e.idx, $time, phase, cnt_bcd, ns_light, ew_light, ped_wait,
                         e.ph, b, l[5:3], l[2:0], e.pw);
            end
        end
    end

    // Hard stop if the run ever stalls.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        ped_req = 1'b0;

        // Held in reset, then release: 02 is visible, then 01, then north-south green at 25.
        step(1'b1, 1'b0, ALLRED_B, 2, 1'b0);
        step(1'b1, 1'b0, ALLRED_B, 2, 1'b0);
        step(1'b0, 1'b0, ALLRED_B, 1, 1'b0);

        // Free-running full cycle, 25/3/2/25/3/2.
        seg(NS_GREEN, 25, 1, 1'b0);
        seg(NS_YELLOW, 3, 1, 1'b0);
        seg(ALLRED_A, 2, 1, 1'b0);
        seg(EW_GREEN, 25, 1, 1'b0);
        seg(EW_YELLOW, 3, 1, 1'b0);
        seg(ALLRED_B, 2, 1, 1'b0);

        // Press at north-south green cnt=20: wait flag next edge, cut to 5 the edge after.
        seg(NS_GREEN, 25, 20, 1'b0);
        step(1'b0, 1'b1, NS_GREEN, 19, PED_EN);
        if (PED_EN) begin
            step(1'b0, 1'b0, NS_GREEN, 5, 1'b0);
            seg(NS_GREEN, 4, 1, 1'b0);
        end else begin
            seg(NS_GREEN, 18, 1, 1'b0);
        end
        seg(NS_YELLOW, 3, 1, 1'b0);
        seg(ALLRED_A, 2, 1, 1'b0);
        seg(EW_GREEN, 25, 1, 1'b0);

        // Press during east-west yellow: stays pending through all-red, cut after green entry.
        step(1'b0, 1'b0, EW_YELLOW, 3, 1'b0);
        step(1'b0, 1'b1, EW_YELLOW, 2, PED_EN);
        step(1'b0, 1'b0, EW_YELLOW, 1, PED_EN);
        seg(ALLRED_B, 2, 1, PED_EN);
        step(1'b0, 1'b0, NS_GREEN, 25, PED_EN);
        if (PED_EN) begin
            step(1'b0, 1'b0, NS_GREEN, 5, 1'b0);
            seg(NS_GREEN, 4, 3, 1'b0);
        end else begin
            seg(NS_GREEN, 24, 3, 1'b0);
        end

        // Press at cnt=3: no lengthening, request dropped, yellow three edges later.
        step(1'b0, 1'b1, NS_GREEN, 2, PED_EN);
        step(1'b0, 1'b0, NS_GREEN, 1, 1'b0);
        seg(NS_YELLOW, 3, 1, 1'b0);
        seg(ALLRED_A, 2, 1, 1'b0);
        seg(EW_GREEN, 25, 12, 1'b0);

        // Reset in the middle of east-west green, then restart into north-south green.
        step(1'b1, 1'b0, ALLRED_B, 2, 1'b0);
        step(1'b1, 1'b0, ALLRED_B, 2, 1'b0);
        step(1'b0, 1'b0, ALLRED_B, 1, 1'b0);
        seg(NS_GREEN, 25, 23, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        #2;
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, need 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
